// File: rtl/vga_sync_out.sv
// 640x480@60 VGA timing generator: pixel-strobe divider, h/v counters, and
// registered sync/colour outputs that only change on the pixel strobe.
module vga_sync_out #(
    parameter int   CLK_DIV  = 4,
    parameter int   H_VIS    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_VIS    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rgb_in,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    // Window bounds are 11 bits so an end bound of exactly 1024 still compares correctly.
    localparam logic [10:0]      H_VIS_E  = 11'(H_VIS);
    localparam logic [10:0]      V_VIS_E  = 11'(V_VIS);
    localparam logic [10:0]      HS_BEG   = 11'(H_VIS + H_FP);
    localparam logic [10:0]      HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0]      VS_BEG   = 11'(V_VIS + V_FP);
    localparam logic [10:0]      VS_END   = 11'(V_VIS + V_FP + V_SYNC);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_sync_out: CLK_DIV must be at least 1");
        end
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_sync_out: line/frame totals must fit 10-bit counters");
        end
    endgenerate

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [7:0]       rgb_q, rgb_d;

    logic        tick;
    logic        h_wrap;
    logic        v_wrap;
    logic        vis;
    logic        hs_act;
    logic        vs_act;
    logic [10:0] h_ext;
    logic [10:0] v_ext;

    always_comb begin
        h_ext  = {1'b0, h_cnt_q};
        v_ext  = {1'b0, v_cnt_q};
        tick   = (div_q == DIV_LAST);
        h_wrap = (h_cnt_q == H_LAST);
        v_wrap = (v_cnt_q == V_LAST);
        vis    = (h_ext < H_VIS_E) && (v_ext < V_VIS_E);
        hs_act = (h_ext >= HS_BEG) && (h_ext < HS_END);
        vs_act = (v_ext >= VS_BEG) && (v_ext < VS_END);
    end

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        if (tick) begin
            h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
            end
            // Outputs take the pre-increment count: a fixed one-pixel lag shared by all three.
            hsync_d = hs_act ? SYNC_POL : ~SYNC_POL;
            vsync_d = vs_act ? SYNC_POL : ~SYNC_POL;
            rgb_d   = vis ? rgb_in : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            rgb_q   <= 8'h00;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign video_on    = vis;
    assign p_tick      = tick;
    assign frame_start = tick && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_sync_out.sv
// Bench for vga_sync_out on a shrunken raster (16x12 counts, 4 clks/pixel) so
// whole frames fit in a short run; a count-based model feeds a scoreboard.
module tb_vga_sync_out;

    localparam int D  = 4;
    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int LINE  = HT * D;
    localparam int FRAME = LINE * VT;
    localparam int HSW   = HS * D;
    localparam int VSW   = VS * LINE;

    logic       clk;
    logic       reset;
    logic [7:0] rgb_in;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       p_tick;
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    logic [7:0] rgb;

    vga_sync_out #(
        .CLK_DIV(D), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .p_tick(p_tick), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int cyc; logic [32:0] v; } exp_t;
    typedef struct { logic rst; logic [7:0] rgb; logic [32:0] v; } vec_t;

    exp_t q[$];
    int   cyc  = 0;
    bit   done = 1'b0;
    int   total = 0;
    int   bad   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [32:0] mk(int px, int py, logic von, logic pt, logic fs,
                                       logic hs, logic vs, logic [7:0] c);
        return {10'(px), 10'(py), von, pt, fs, hs, vs, c};
    endfunction

    // Model: s = clock edges since the last reset edge; counts follow arithmetically.
    int         s;
    logic       m_hs, m_vs;
    logic [7:0] m_rgb;

    function automatic int m_h();
        return (s / D) % HT;
    endfunction
    function automatic int m_v();
        return (s / (D * HT)) % VT;
    endfunction
    function automatic logic m_pt();
        return (s % D) == D - 1;
    endfunction
    function automatic logic [32:0] m_exp();
        int h, v;
        h = m_h();
        v = m_v();
        return mk(h, v, (h < HV) && (v < VV), m_pt(), m_pt() && h == 0 && v == 0,
                  m_hs, m_vs, m_rgb);
    endfunction

    // Called 2ns after a rising edge; drives inputs for the next edge.
    task automatic step(input logic r, input int md);
        int h, v;
        logic [7:0] c;
        h = m_h();
        v = m_v();
        c = (md == 0) ? 8'hA5 : (8'((h << 4) | v) ^ 8'h3C);
        reset  = r;
        rgb_in = c;
        if (r) begin
            s = 0; m_hs = 1'b1; m_vs = 1'b1; m_rgb = 8'h00;
        end else begin
            if (m_pt()) begin
                m_hs  = (h >= HV + HF && h < HV + HF + HS) ? 1'b0 : 1'b1;
                m_vs  = (v >= VV + VF && v < VV + VF + VS) ? 1'b0 : 1'b1;
                m_rgb = (h < HV && v < VV) ? c : 8'h00;
            end
            s++;
        end
        q.push_back('{cyc + 1, m_exp()});
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n, input int md);
        for (int i = 0; i < n; i++) step(1'b0, md);
    endtask

    vec_t tbl[18];

    initial begin
        reset  = 1'b1;
        rgb_in = 8'hFF;
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, (i < 5) ? 8'hFF : 8'(8'h11 * i), mk(0, 0, 1, 0, 0, 1, 1, 8'h00)};
        tbl[10] = '{1'b0, 8'hFF, mk(0, 0, 1, 0, 0, 1, 1, 8'h00)};
        tbl[11] = '{1'b0, 8'hFF, mk(0, 0, 1, 0, 0, 1, 1, 8'h00)};
        tbl[12] = '{1'b0, 8'hFF, mk(0, 0, 1, 1, 1, 1, 1, 8'h00)};
        tbl[13] = '{1'b0, 8'hFF, mk(1, 0, 1, 0, 0, 1, 1, 8'hFF)};
        tbl[14] = '{1'b0, 8'hFF, mk(1, 0, 1, 0, 0, 1, 1, 8'hFF)};
        tbl[15] = '{1'b0, 8'hFF, mk(1, 0, 1, 0, 0, 1, 1, 8'hFF)};
        tbl[16] = '{1'b0, 8'hFF, mk(1, 0, 1, 1, 0, 1, 1, 8'hFF)};
        tbl[17] = '{1'b0, 8'hFF, mk(2, 0, 1, 0, 0, 1, 1, 8'hFF)};

        @(posedge clk);
        #2;
        for (int i = 0; i < 18; i++) begin
            reset  = tbl[i].rst;
            rgb_in = tbl[i].rgb;
            q.push_back('{cyc + 1, tbl[i].v});
            @(posedge clk);
            #2;
        end

        s = 8; m_hs = 1'b1; m_vs = 1'b1; m_rgb = 8'hFF;
        run(2 * FRAME + LINE, 0);
        run(FRAME, 1);
        for (int i = 0; i < FRAME && !(m_h() == 5 && m_v() == 4 && s % D == 1); i++)
            step(1'b0, 1);
        step(1'b1, 1);
        run(2 * FRAME + LINE, 0);
        done = 1'b1;
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
        end
    endtask

    initial begin
        logic [32:0] act;
        exp_t e;
        logic hs_prev, vs_prev;
        int hs_fall, vs_fall, fs_last;
        int n_hp, n_vp, n_fs, n_vw;
        hs_prev = 1'b1; vs_prev = 1'b1;
        hs_fall = -1; vs_fall = -1; fs_last = -1;
        n_hp = 0; n_vp = 0; n_fs = 0; n_vw = 0;
        while (!done) begin
            @(negedge clk);
            act = {pixel_x, pixel_y, video_on, p_tick, frame_start, hsync, vsync, rgb};
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("scoreboard", longint'(act), longint'(e.v));
            end
            if (reset) begin
                hs_fall = -1; vs_fall = -1; fs_last = -1;
            end else begin
                if (hs_prev && !hsync) begin
                    if (hs_fall >= 0) begin chk("hsync_period", cyc - hs_fall, LINE); n_hp++; end
                    hs_fall = cyc;
                end
                if (!hs_prev && hsync && hs_fall >= 0) chk("hsync_width", cyc - hs_fall, HSW);
                if (vs_prev && !vsync) begin
                    if (vs_fall >= 0) begin chk("vsync_period", cyc - vs_fall, FRAME); n_vp++; end
                    vs_fall = cyc;
                end
                if (!vs_prev && vsync && vs_fall >= 0) begin chk("vsync_width", cyc - vs_fall, VSW); n_vw++; end
                if (frame_start) begin
                    if (fs_last >= 0) chk("frame_period", cyc - fs_last, FRAME);
                    fs_last = cyc;
                    n_fs++;
                end
            end
            hs_prev = hsync;
            vs_prev = vsync;
        end
        repeat (2) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        chk("hsync_periods_seen", (n_hp >= 50) ? 1 : 0, 1);
        chk("vsync_periods_seen", (n_vp >= 2) ? 1 : 0, 1);
        chk("vsync_widths_seen", (n_vw >= 4) ? 1 : 0, 1);
        chk("frame_starts_seen", (n_fs >= 6) ? 1 : 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
